// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single data memory.
// Ports: clk, reset, p0_*/p1_* requesters (core, loader), mem_* shared dmem side.
module dmem_arbiter #(
  parameter int XLEN      = 32,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            p0_valid,
  input  logic            p0_lock,
  input  logic            p0_we,
  input  logic [XLEN-1:0] p0_addr,
  input  logic [XLEN-1:0] p0_wdata,
  input  logic [XLEN-1:0] p0_wmask,
  output logic            p0_ready,
  output logic            p0_rvalid,
  output logic [XLEN-1:0] p0_rdata,
  input  logic            p1_valid,
  input  logic            p1_lock,
  input  logic            p1_we,
  input  logic [XLEN-1:0] p1_addr,
  input  logic [XLEN-1:0] p1_wdata,
  input  logic [XLEN-1:0] p1_wmask,
  output logic            p1_ready,
  output logic            p1_rvalid,
  output logic [XLEN-1:0] p1_rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [XLEN-1:0] mem_wmask,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] BLAST = 4'(MAX_BURST - 1);

  state_t     state;
  logic       last;
  logic [3:0] bcnt;

  logic acc0;
  logic acc1;
  logic cur;
  logic own_valid;
  logic own_lock;
  logic oth_valid;
  logic release_own;
  logic idle_pick;

  // Ready follows valid of the owner; reset masks every grant.
  always_comb begin
    p0_ready = !reset && (state == OWN0) && p0_valid;
    p1_ready = !reset && (state == OWN1) && p1_valid;
    acc0     = p0_ready;
    acc1     = p1_ready;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_we    = 1'b0;
    unique case (1'b1)
      acc0: begin
        mem_addr  = p0_addr;
        mem_wdata = p0_wdata;
        mem_wmask = p0_wmask;
        mem_we    = p0_we;
      end
      acc1: begin
        mem_addr  = p1_addr;
        mem_wdata = p1_wdata;
        mem_wmask = p1_wmask;
        mem_we    = p1_we;
      end
      default: ;
    endcase
  end

  // Owner-relative view; in OWNx a valid owner beat is always accepted.
  always_comb begin
    cur         = (state == OWN1);
    own_valid   = cur ? p1_valid : p0_valid;
    own_lock    = cur ? p1_lock  : p0_lock;
    oth_valid   = cur ? p0_valid : p1_valid;
    release_own = !own_valid || !own_lock ||
                  ((bcnt == BLAST) && oth_valid);
    // Prefer the port that was not granted last.
    idle_pick   = last ? !p0_valid : p1_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      bcnt      <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= acc0 && !p0_we;
      p1_rvalid <= acc1 && !p1_we;
      if (acc0 && !p0_we)
        p0_rdata <= mem_rdata;
      if (acc1 && !p1_we)
        p1_rdata <= mem_rdata;

      unique case (state)
        IDLE: begin
          if (p0_valid || p1_valid) begin
            state <= idle_pick ? OWN1 : OWN0;
            last  <= idle_pick;
            bcnt  <= '0;
          end
        end
        OWN0, OWN1: begin
          if (release_own) begin
            bcnt <= '0;
            if (oth_valid) begin
              state <= cur ? OWN0 : OWN1;
              last  <= !cur;
            end else begin
              state <= IDLE;
            end
          end else if (bcnt != 4'hF) begin
            bcnt <= bcnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          bcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data/address width in bits.
REQ-002 Parameter MAX_BURST, default 4, max consecutive beats one port may hold under contention; legal range 1..15.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 p0_valid  input  1  port 0 (core) beat request.
REQ-006 p0_lock  input  1  port 0 requests to keep ownership after the current beat.
REQ-007 p0_we  input  1  port 0 beat is a write (0 = read).
REQ-008 p0_addr, p0_wdata, p0_wmask  input  XLEN each  port 0 address, write data, byte-lane write mask.
REQ-009 p0_ready  output  1  port 0 beat accepted this cycle.
REQ-010 p0_rvalid  output  1  port 0 read data valid.
REQ-011 p0_rdata  output  XLEN  port 0 read data.
REQ-012 p1_* (valid, lock, we, addr, wdata, wmask, ready, rvalid, rdata)  same directions and widths as port 0; port 1 is the loader/debug port.
REQ-013 mem_addr, mem_wdata, mem_wmask  output  XLEN each  shared dmem request.
REQ-014 mem_we  output  1  dmem write strobe.
REQ-015 mem_rdata  input  XLEN  dmem read data, combinational from mem_addr.

Function
REQ-016 FSM states: IDLE, OWN0, OWN1; registered state plus last-granted pointer (last) and burst counter (bcnt, 4 bits).
REQ-017 IDLE: no pX_ready asserted; if any pX_valid, next state OWNx, with x chosen round-robin: the port not equal to last wins if it is valid, otherwise the single valid port wins; last <= x; bcnt <= 0.
REQ-018 Arbitration latency: exactly one cycle from IDLE to first grant.
REQ-019 OWNx: px_ready = px_valid (combinational); other port's ready = 0.
REQ-020 Accepted beat = px_valid && px_ready; on an accepted beat mem_addr/mem_wdata/mem_wmask = port x values and mem_we = px_we; otherwise all mem_* outputs = 0.
REQ-021 On each accepted beat bcnt <= bcnt + 1, saturating at 15.
REQ-022 Release from OWNx occurs on: px_valid = 0; or accepted beat with px_lock = 0; or accepted beat with bcnt = MAX_BURST-1 while the other port's valid = 1 (forced release, overriding lock).
REQ-023 On release: if the other port's valid = 1, next state is OWN(other), last <= other, bcnt <= 0 (zero-bubble handover); else next state IDLE.
REQ-024 Locked ownership with no contender does not release on bcnt; bcnt saturates.
REQ-025 Read return: on an accepted read beat of port x, px_rdata <= mem_rdata and px_rvalid <= 1 on the next edge; px_rvalid is 0 in every other cycle; px_rdata holds its last value.
REQ-026 Writes have no response; completion is the accepted cycle.
REQ-027 The non-owning port's rvalid may be 1 in the first cycle after handover (previous owner's last read); both rvalids are never 1 in the same cycle.
REQ-028 Requesters keep valid and payload stable until ready; deasserting valid before ready is legal and causes release per REQ-022.

Reset
REQ-029 While reset = 1 at a rising edge: state <= IDLE, last <= 1 (port 0 wins the first contention), bcnt <= 0, p0_rvalid = p1_rvalid <= 0, p0_rdata = p1_rdata <= 0.
REQ-030 Reset during ownership or with a read in flight aborts it: no rvalid is produced for that beat, and mem_we = 0 in the cycle following reset.
REQ-031 All outputs during reset: all pX_ready = 0, mem_* = 0.

Verification
REQ-032 Reset, then p0_valid and p1_valid rise together (lock = 0) -> cycle 1 OWN0, p0 beat accepted; cycle 2 OWN1, p1 beat accepted; alternation continues while both are held.
REQ-033 p0 read at addr 0x40 with mem model returning 0xDEADBEEF -> p0_ready in the grant cycle, p0_rvalid = 1 and p0_rdata = 0xDEADBEEF exactly one cycle later, p1_rvalid stays 0.
REQ-034 MAX_BURST = 4: p1 locked streaming writes; p0_valid rises mid-burst -> p1 gets exactly 4 accepted beats from grant, then OWN0 on the next cycle with no idle bubble.
REQ-035 p0 locked alone for 20 beats -> 20 consecutive accepted beats, bcnt saturates at 15, no release.
REQ-036 Write p1 addr 0x3000_0000, wdata 0x12, wmask 0xFF -> mem_we = 1 for exactly one cycle with those values; mem_* = 0 in surrounding cycles.
REQ-037 Reset asserted in the cycle a p0 read is accepted -> p0_rvalid remains 0, state IDLE, next contention granted to port 0.
